// File: rtl/asyn_fifo_pkg.sv
// Gray/binary pointer helpers shared by the write- and read-side FIFO controllers.
// Functions work at a fixed maximum width; narrower pointers are zero-extended.
package asyn_fifo_pkg;

   localparam int unsigned MAX_W = 13;

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended upper bits leave the prefix XOR unaffected.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b[MAX_W-1] = g[MAX_W-1];
      for (int i = int'(MAX_W) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (MSB-first XOR prefix), shared with the read side.
module gray2bin_conv #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   always_comb begin
      bin_o      = '0;
      bin_o[W-1] = gray_i[W-1];
      for (int i = int'(W) - 2; i >= 0; i--) begin
         bin_o[i] = bin_o[i+1] ^ gray_i[i];
      end
   end

endmodule

// File: rtl/asyn_fifo_wctrl.sv
// Write-domain pointer/flag controller for the asynchronous FIFO: Gray pointer export,
// full / almost-full detection, free-entry count and sticky overflow.
module asyn_fifo_wctrl
   import asyn_fifo_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = 3,
   parameter int unsigned AF_THRESH = (1 << ADDR_SIZE) - 2
) (
   input  logic                 wclk,
   input  logic                 wrst,
   input  logic                 wpush,
   input  logic [ADDR_SIZE:0]   sync_rptr,
   input  logic                 wovf_clr,
   output logic                 wen,
   output logic [ADDR_SIZE-1:0] waddr,
   output logic [ADDR_SIZE:0]   wptr,
   output logic                 wfull,
   output logic                 walmost_full,
   output logic [ADDR_SIZE:0]   wfree_cnt,
   output logic                 woverflow
);

   localparam int unsigned PW    = ADDR_SIZE + 1;
   localparam int unsigned DEPTH = 1 << ADDR_SIZE;

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wptr_q, wgray_d;
   logic [PW-1:0] wfree_q, wfree_d;
   logic [PW-1:0] rbin, used_d, full_ref;
   logic          wfull_q, wfull_d;
   logic          waf_q, waf_d;
   logic          wovf_q, wovf_d;

   gray2bin_conv #(.W(PW)) u_rptr_g2b (
      .gray_i (sync_rptr),
      .bin_o  (rbin)
   );

   assign wen = wpush & ~wfull_q;

   // Next pointer and flags, all derived from the post-increment pointer so flags never lag a write.
   always_comb begin
      wbin_d   = wbin_q + PW'(wen);
      wgray_d  = PW'(bin2gray(MAX_W'(wbin_d)));
      full_ref = {~sync_rptr[ADDR_SIZE:ADDR_SIZE-1], sync_rptr[ADDR_SIZE-2:0]};
      wfull_d  = (wgray_d == full_ref);
      used_d   = wbin_d - rbin;
      wfree_d  = PW'(DEPTH) - used_d;
      waf_d    = (32'(used_d) >= AF_THRESH);
      wovf_d   = wovf_q;
      if (wovf_clr)
         wovf_d = 1'b0;
      if (wpush & wfull_q)
         wovf_d = 1'b1;
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         wfull_q <= 1'b0;
         wfree_q <= PW'(DEPTH);
         waf_q   <= 1'b0;
         wovf_q  <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wgray_d;
         wfull_q <= wfull_d;
         wfree_q <= wfree_d;
         waf_q   <= waf_d;
         wovf_q  <= wovf_d;
      end
   end

   assign waddr        = wbin_q[ADDR_SIZE-1:0];
   assign wptr         = wptr_q;
   assign wfull        = wfull_q;
   assign walmost_full = waf_q;
   assign wfree_cnt    = wfree_q;
   assign woverflow    = wovf_q;

endmodule
